mc_ctrl: RTL
============

// Module: mc_ctrl
// PURPOSE
//  Multi-cycle MIPS control FSM; drives the ALU's op/func/aluop inputs and consumes its zero flag.
//  Sequences FETCH/DECODE/EXE/MEM/WB and emits datapath write enables and mux selects.
//  Sits between instruction memory and the datapath (PC, IR, GRF, DM, ALU) in the P5 core.
// PARAMETERS
//  RST_PC    32'h0000_3000  reset PC value, passed to the datapath as pc_init
//  CNT_W     32             width of the perf counters (INSTR_CNT_EN only)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  instr      in   32  instruction word from IM; sampled when ir_we=1
//  zero       in   1   ALU zero flag, from the ALU's aluresult==0
//  op         out  6   latched instr[31:26] to the ALU
//  func       out  6   latched instr[5:0] to the ALU
//  aluop      out  2   00 add, 01 sub, 10 decode by func, 11 decode by op
//  pc_we      out  1   PC write enable
//  ir_we      out  1   IR write enable (also latches op/func)
//  reg_we     out  1   GRF write enable
//  mem_we     out  1   DM write enable
//  alu_src_b  out  2   00 rt, 01 const 4, 10 ext imm
//  ext_op     out  2   00 zero-ext, 01 sign-ext, 10 lui (imm<<16)
//  reg_dst    out  2   00 rt, 01 rd, 10 $31
//  mem_to_reg out  2   00 ALUOut, 01 DM data, 10 PC(+4)
//  npc_sel    out  2   00 ALU (PC+4), 01 branch target, 10 j target, 11 rs
//  pc_init    out  32  constant RST_PC
//  illegal    out  1   one-cycle pulse in DECODE for an unsupported op/func
// BEHAVIOUR
//  Supported: addu subu jr (R), ori lui lw sw beq j jal. Anything else is illegal.
//  States: RST, FETCH, DECODE, EXE, MEMRD, MEMWR, WBALU, WBMEM, BRANCH, JUMP.
//  Outputs are Moore: decoded from the state register plus latched op/func only.
//  Reset: state=RST, op=func=0. In RST all enables=0, selects=0, illegal=0.
//   RST->FETCH unconditionally on the first edge after rst_n rises.
//  FETCH: ir_we=1, pc_we=1, alu_src_b=01, aluop=00, npc_sel=00.
//   ->DECODE.
//  DECODE: aluop=00, alu_src_b=10, ext_op=01 (branch target precompute).
//   R addu/subu, ori, lui -> EXE; lw/sw -> EXE; beq -> BRANCH;
//   j/jal/jr -> JUMP; illegal -> FETCH with illegal=1, no writes.
//  EXE: R: aluop=10, alu_src_b=00. ori: aluop=11, ext_op=00.
//   lui: aluop=11, ext_op=10. lw/sw: aluop=00, ext_op=01.
//   lw->MEMRD, sw->MEMWR, else->WBALU.
//  MEMRD->WBMEM; MEMWR: mem_we=1, ->FETCH.
//  WBALU: reg_we=1, mem_to_reg=00, reg_dst=01 for R else 00, ->FETCH.
//  WBMEM: reg_we=1, mem_to_reg=01, reg_dst=00, ->FETCH.
//  BRANCH: aluop=01, alu_src_b=00; pc_we=zero, npc_sel=01; ->FETCH.
//  JUMP: pc_we=1. j/jal: npc_sel=10; jr: npc_sel=11.
//   jal also sets reg_we=1, reg_dst=10, mem_to_reg=10. ->FETCH.
//  Latency in cycles: beq/j/jal/jr 3; R/ori/lui/sw 4; lw 5.
//  At most one of pc_we, reg_we, mem_we is asserted per state, except jal in JUMP (pc_we+reg_we).
//  rst_n asserted mid-instruction: state goes to RST immediately (async).
//   All enables drop in the same cycle; the partial instruction is discarded.
//  func is don't-care for non-R ops, but is still latched.
// CONFIGURATION
//  INSTR_CNT_EN defined:
//   extra outputs cyc_cnt[CNT_W] (+1 every non-RST cycle) and ret_cnt[CNT_W]
//   (+1 on every FETCH entry from a non-RST state). Both are 0 on reset and wrap at 2^CNT_W.
//  INSTR_CNT_EN undefined: these ports and their counters do not exist.
// STRUCTURE
//  ctrl_defs.vh (shared include): state codes; opcode/func localparams;
//   aluop, alu_src_b, ext_op, reg_dst, mem_to_reg, npc_sel encodings.
//  Sub-module mc_ctrl_dec (combinational): op/func -> instruction class and illegal flag.
//   Used by the DECODE/EXE transitions. The FSM and output decode stay in mc_ctrl.
// TESTING
//  Reset then release, instr=ori $1,$0,1 (3401_0001):
//   RST,FETCH(ir_we,pc_we),DECODE,EXE(aluop=11,ext_op=00),WBALU(reg_we,reg_dst=00).
//  instr=addu $3,$1,$2 (0022_1821): EXE aluop=10, func=100001; WBALU reg_dst=01; 4 cycles total.
//  instr=lw (8C22_0004): 5 cycles, WBMEM mem_to_reg=01. sw (AC22_0004): MEMWR mem_we=1, 4 cycles.
//  beq (1022_0003) with zero=1: BRANCH pc_we=1, npc_sel=01. With zero=0: pc_we=0. 3 cycles.
//  jal (0C00_0C00): JUMP pc_we=1, reg_we=1, reg_dst=10, mem_to_reg=10.
//   instr=FC00_0000: illegal=1 in DECODE, next FETCH, no writes.
//  rst_n=0 during lw MEMRD: all enables 0 at once, no WBMEM.
//   With INSTR_CNT_EN: after 2 ori + 1 beq, ret_cnt=3, cyc_cnt=11.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: state codes, opcode/func values, instruction classes and datapath select encodings
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_EXE, S_MEMRD, S_MEMWR, S_WBALU, S_WBMEM, S_BRANCH, S_JUMP
  } state_t;
  typedef enum logic [3:0] {
    C_ILL, C_R, C_JR, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL
  } cls_t;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ORI  = 6'h0d;
  localparam logic [5:0] OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2b;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_OP   = 2'b11;
  localparam logic [1:0] SRCB_RT  = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] DST_RT   = 2'b00;
  localparam logic [1:0] DST_RD   = 2'b01;
  localparam logic [1:0] DST_RA   = 2'b10;
  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_PC   = 2'b10;
  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_J    = 2'b10;
  localparam logic [1:0] NPC_RS   = 2'b11;
endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_ctrl_dec: classifies a latched op/func pair into an instruction class and flags unsupported encodings
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output logic [3:0] o_cls,
  output logic       o_illegal
);
  // opcode/func lookup; R-type only accepts addu, subu and jr
  always_comb begin
    o_cls = C_ILL;
    case (i_op)
      OP_R:    o_cls = (i_func == FN_ADDU || i_func == FN_SUBU) ? C_R : (i_func == FN_JR) ? C_JR : C_ILL;
      OP_ORI:  o_cls = C_ORI;
      OP_LUI:  o_cls = C_LUI;
      OP_LW:   o_cls = C_LW;
      OP_SW:   o_cls = C_SW;
      OP_BEQ:  o_cls = C_BEQ;
      OP_J:    o_cls = C_J;
      OP_JAL:  o_cls = C_JAL;
      default: o_cls = C_ILL;
    endcase
  end
  assign o_illegal = (o_cls == C_ILL);
endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM; optional perf counters under INSTR_CNT_EN
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter logic [31:0] RST_PC = 32'h0000_3000
`ifdef INSTR_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] i_instr,
  input  logic        i_zero,
  output logic [5:0]  o_op,
  output logic [5:0]  o_func,
  output logic [1:0]  o_aluop,
  output logic        o_pc_we,
  output logic        o_ir_we,
  output logic        o_reg_we,
  output logic        o_mem_we,
  output logic [1:0]  o_alu_src_b,
  output logic [1:0]  o_ext_op,
  output logic [1:0]  o_reg_dst,
  output logic [1:0]  o_mem_to_reg,
  output logic [1:0]  o_npc_sel,
  output logic [31:0] o_pc_init,
  output logic        o_illegal
`ifdef INSTR_CNT_EN
  , output logic [CNT_W-1:0] o_cyc_cnt
  , output logic [CNT_W-1:0] o_ret_cnt
`endif
);
  state_t     r_state;
  logic [5:0] r_op;
  logic [5:0] r_func;
  logic [3:0] w_cls;
  logic       w_illegal;
  logic       w_unused;
  assign w_unused  = ^i_instr[25:6];
  assign o_op      = r_op;
  assign o_func    = r_func;
  assign o_pc_init = RST_PC;
  mc_ctrl_dec u_dec (
    .i_op      (r_op),
    .i_func    (r_func),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );
  // state sequencing and op/func latch, which tracks the IR write in FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
      r_op    <= '0;
      r_func  <= '0;
    end else begin
      if (r_state == S_FETCH) begin
        r_op   <= i_instr[31:26];
        r_func <= i_instr[5:0];
      end
      case (r_state)
        S_RST:    r_state <= S_FETCH;
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: r_state <= w_illegal ? S_FETCH : (w_cls == C_BEQ) ? S_BRANCH :
                             (w_cls == C_J || w_cls == C_JAL || w_cls == C_JR) ? S_JUMP : S_EXE;
        S_EXE:    r_state <= (w_cls == C_LW) ? S_MEMRD : (w_cls == C_SW) ? S_MEMWR : S_WBALU;
        S_MEMRD:  r_state <= S_WBMEM;
        default:  r_state <= S_FETCH;
      endcase
    end
  end
  // Moore output decode from state and latched class; branch PC write follows the live zero flag
  always_comb begin
    o_ir_we      = 1'b0;
    o_pc_we      = 1'b0;
    o_reg_we     = 1'b0;
    o_mem_we     = 1'b0;
    o_illegal    = 1'b0;
    o_aluop      = ALU_ADD;
    o_alu_src_b  = SRCB_RT;
    o_ext_op     = EXT_ZERO;
    o_reg_dst    = DST_RT;
    o_mem_to_reg = M2R_ALU;
    o_npc_sel    = NPC_PC4;
    case (r_state)
      S_FETCH: begin
        o_ir_we     = 1'b1;
        o_pc_we     = 1'b1;
        o_alu_src_b = SRCB_4;
      end
      S_DECODE: begin
        o_alu_src_b = SRCB_IMM;
        o_ext_op    = EXT_SIGN;
        o_illegal   = w_illegal;
      end
      S_EXE: begin
        o_aluop     = (w_cls == C_R) ? ALU_FUNC : (w_cls == C_ORI || w_cls == C_LUI) ? ALU_OP : ALU_ADD;
        o_alu_src_b = (w_cls == C_R) ? SRCB_RT : SRCB_IMM;
        o_ext_op    = (w_cls == C_ORI || w_cls == C_R) ? EXT_ZERO : (w_cls == C_LUI) ? EXT_LUI : EXT_SIGN;
      end
      S_MEMWR: o_mem_we = 1'b1;
      S_WBALU: begin
        o_reg_we  = 1'b1;
        o_reg_dst = (w_cls == C_R) ? DST_RD : DST_RT;
      end
      S_WBMEM: begin
        o_reg_we     = 1'b1;
        o_mem_to_reg = M2R_MEM;
      end
      S_BRANCH: begin
        o_aluop   = ALU_SUB;
        o_pc_we   = i_zero;
        o_npc_sel = NPC_BR;
      end
      S_JUMP: begin
        o_pc_we      = 1'b1;
        o_npc_sel    = (w_cls == C_JR) ? NPC_RS : NPC_J;
        o_reg_we     = (w_cls == C_JAL);
        o_reg_dst    = (w_cls == C_JAL) ? DST_RA : DST_RT;
        o_mem_to_reg = (w_cls == C_JAL) ? M2R_PC : M2R_ALU;
      end
      default: ;
    endcase
  end
`ifdef INSTR_CNT_EN
  logic w_ret;
  assign w_ret = (r_state inside {S_MEMWR, S_WBALU, S_WBMEM, S_BRANCH, S_JUMP}) ||
                 (r_state == S_DECODE && w_illegal);
  // cycle counter excludes RST; retire counter bumps on each return to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_cyc_cnt <= '0;
      o_ret_cnt <= '0;
    end else begin
      if (r_state != S_RST) o_cyc_cnt <= o_cyc_cnt + CNT_W'(1);
      if (w_ret) o_ret_cnt <= o_ret_cnt + CNT_W'(1);
    end
  end
`endif
endmodule
